// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_rx_monitor
// Purpose  : Receive-side monitor for the VGA output bundle. Recovers active
//            pixel coordinates and colour, pulses on every frame start, checks
//            line/frame/sync timing against the parameters and locks once
//            LOCK_FRAMES consecutive clean frames have been seen.
// Ports    : CLOCK_50, reset                 system clock, sync active-high reset
//            vga_clk, vga_hs, vga_vs,        observed VGA bundle (sync active low,
//            vga_blank_n, vga_r/g/b          blank_n high during active video)
//            rx_valid, rx_x, rx_y, rx_r/g/b  one pulse per active pixel + data
//            frame_start                     pulse on each VS falling edge
//            locked                          stream conforms to the parameters
//            err_pulse, err_count            violation pulse, saturating count
// Revision : 1.0 - initial release
// ============================================================================
module vga_rx_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       vga_clk,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  output logic       rx_valid,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic [7:0] rx_r,
  output logic [7:0] rx_g,
  output logic [7:0] rx_b,
  output logic       frame_start,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [2:0]  r_clk_sync;
  logic        w_pix_en;
  logic        r_hs_in;
  logic        r_vs_in;
  logic        r_blank_in;
  logic [23:0] r_rgb_in;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  r_ax;
  logic [9:0]  r_ay;
  logic        r_line_act;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_good;
  logic [7:0]  w_good_nxt;
  logic [7:0]  w_good_inc;
  logic        w_hs_fall;
  logic        w_hs_rise;
  logic        w_vs_fall;
  logic        w_vs_rise;
  logic [10:0] w_h_len;
  logic [10:0] w_v_len;
  logic [10:0] w_v_low;
  logic        w_viol;
  logic        w_err;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // vga_clk is asynchronous to CLOCK_50: two flops for metastability, a third
  // to find the rising edge. Data inputs get a single register so that they
  // are sampled well inside the pixel period by the time pix_en fires.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_hs_in    <= 1'b0;
      r_vs_in    <= 1'b0;
      r_blank_in <= 1'b0;
      r_rgb_in   <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], vga_clk};
      r_hs_in    <= vga_hs;
      r_vs_in    <= vga_vs;
      r_blank_in <= vga_blank_n;
      r_rgb_in   <= {vga_r, vga_g, vga_b};
    end
  end

  assign w_pix_en  = r_clk_sync[1] & ~r_clk_sync[2];

  assign w_hs_fall = w_pix_en &  r_hs_prev & ~r_hs_in;
  assign w_hs_rise = w_pix_en & ~r_hs_prev &  r_hs_in;
  assign w_vs_fall = w_pix_en &  r_vs_prev & ~r_vs_in;
  assign w_vs_rise = w_pix_en & ~r_vs_prev &  r_vs_in;

  // h_cnt holds the index of the previous sample within the line, so the
  // length of the line (or of the HS low pulse) ending now is h_cnt+1.
  assign w_h_len = {1'b0, r_h_cnt} + 11'd1;
  assign w_v_len = {1'b0, r_v_cnt} + 11'd1;
  // VS usually rises together with an HS fall; that fall closes the last
  // sync line and has not yet been counted into v_cnt.
  assign w_v_low = {1'b0, r_v_cnt} + {10'd0, w_hs_fall};

  assign w_viol = (w_hs_fall & (w_h_len != 11'(H_TOTAL)))
                | (w_hs_rise & (w_h_len != 11'(H_SYNC)))
                | (w_vs_fall & (w_v_len != 11'(V_TOTAL)))
                | (w_vs_rise & (w_v_low != 11'(V_SYNC)))
                | (w_hs_fall & (r_ax != 10'd0) & (r_ax != 10'(H_ACTIVE)))
                | (w_vs_fall & (r_ay != 10'(V_ACTIVE)));

  assign w_err      = w_viol & (r_state != ST_HUNT);
  assign w_good_inc = r_good + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      ST_HUNT: begin
        if (w_vs_fall) begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = 8'd0;
        end
      end
      ST_MEASURE: begin
        if (w_err) begin
          w_state_nxt = ST_HUNT;
        end else if (w_vs_fall) begin
          // Any violation would already have sent us to HUNT, so reaching a
          // VS fall here means the frame just closed was clean.
          w_good_nxt = w_good_inc;
          if (w_good_inc >= 8'(LOCK_FRAMES)) begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_line_act  <= 1'b0;
      r_state     <= ST_HUNT;
      r_good      <= '0;
      rx_valid    <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_r        <= '0;
      rx_g        <= '0;
      rx_b        <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      err_pulse   <= w_err;
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      locked      <= (w_state_nxt == ST_LOCKED);
      if (w_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (w_pix_en) begin
        r_hs_prev   <= r_hs_in;
        r_vs_prev   <= r_vs_in;
        frame_start <= w_vs_fall;
        r_h_cnt     <= w_hs_fall ? 10'd0 : sat_inc(r_h_cnt);

        if (w_vs_fall) begin
          r_v_cnt <= '0;
        end else if (w_hs_fall) begin
          r_v_cnt <= sat_inc(r_v_cnt);
        end

        if (w_hs_fall) begin
          r_ax       <= '0;
          r_line_act <= 1'b0;
        end else if (r_blank_in) begin
          r_ax       <= sat_inc(r_ax);
          r_line_act <= 1'b1;
        end

        if (w_vs_fall) begin
          r_ay <= '0;
        end else if (w_hs_fall && r_line_act) begin
          r_ay <= sat_inc(r_ay);
        end

        if (r_blank_in) begin
          rx_valid <= 1'b1;
          rx_x     <= r_ax;
          rx_y     <= r_ay;
          rx_r     <= r_rgb_in[23:16];
          rx_g     <= r_rgb_in[15:8];
          rx_b     <= r_rgb_in[7:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rx_monitor
// Purpose  : Self-checking bench for vga_rx_monitor using a shrunken raster
//            (10x7 total, 5x3 active) with random pixel colours and directed
//            timing faults, compared pixel by pixel against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rx_monitor;

  localparam int H_ACTIVE = 5;
  localparam int H_TOTAL  = 10;
  localparam int H_SYNC   = 2;
  localparam int V_ACTIVE = 3;
  localparam int V_TOTAL  = 7;
  localparam int V_SYNC   = 2;
  localparam int LOCK_FR  = 2;
  localparam int H_START  = 3;   // first active pixel in a line
  localparam int V_START  = 3;   // first active line in a frame

  localparam int M_HUNT = 0;
  localparam int M_MEAS = 1;
  localparam int M_LOCK = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       vga_clk = 1'b0;
  logic       vga_hs = 1'b1;
  logic       vga_vs = 1'b1;
  logic       vga_blank_n = 1'b0;
  logic [7:0] vga_r = '0;
  logic [7:0] vga_g = '0;
  logic [7:0] vga_b = '0;
  logic       rx_valid;
  logic [9:0] rx_x;
  logic [9:0] rx_y;
  logic [7:0] rx_r;
  logic [7:0] rx_g;
  logic [7:0] rx_b;
  logic       frame_start;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  vga_rx_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
    .LOCK_FRAMES(LOCK_FR)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .vga_clk(vga_clk),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y),
    .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .frame_start(frame_start), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Outputs seen during the current pixel window.
  int          ov, ofs, oe;
  logic [9:0]  ox, oy;
  logic [23:0] orgb;

  // Expected response to the previously sent pixel.
  bit          have_pend;
  int          p_valid, p_fs, p_err, p_locked, p_ec;
  logic [9:0]  p_x, p_y;
  logic [23:0] p_rgb;

  // Reference model: positions are tracked as sample indices and running
  // totals of HS falls, and the rules are evaluated on those.
  int m_idx, m_last_hsf, m_nhsf, m_nhsf_vsf, m_ax, m_ay, m_state, m_good, m_ec;
  bit m_line_act, m_phs, m_pvs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_last_hsf = -1; m_nhsf = 0; m_nhsf_vsf = 0;
    m_ax = 0; m_ay = 0; m_state = M_HUNT; m_good = 0; m_ec = 0;
    m_line_act = 0; m_phs = 0; m_pvs = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit bl, input logic [23:0] rgb);
    bit hf, hr, vf, vr, e;
    int h_pre, v_pre;
    hf = m_phs && !hs;
    hr = !m_phs && hs;
    vf = m_pvs && !vs;
    vr = !m_pvs && vs;
    h_pre = m_idx - m_last_hsf - 1;
    if (h_pre > 1023) h_pre = 1023;
    v_pre = m_nhsf - m_nhsf_vsf;
    if (v_pre > 1023) v_pre = 1023;
    e = 0;
    if (hf && (h_pre + 1 != H_TOTAL)) e = 1;
    if (hr && (h_pre + 1 != H_SYNC)) e = 1;
    if (vf && (v_pre + 1 != V_TOTAL)) e = 1;
    if (vr && (v_pre + int'(hf) != V_SYNC)) e = 1;
    if (hf && m_ax != 0 && m_ax != H_ACTIVE) e = 1;
    if (vf && m_ay != V_ACTIVE) e = 1;
    if (m_state == M_HUNT) e = 0;

    p_valid = int'(bl);
    p_x     = 10'(m_ax);
    p_y     = 10'(m_ay);
    p_rgb   = rgb;
    p_fs    = int'(vf);
    p_err   = int'(e);

    if (e) begin
      m_state = M_HUNT;
      if (m_ec < 255) m_ec++;
    end else if (vf) begin
      if (m_state == M_HUNT) begin
        m_state = M_MEAS;
        m_good  = 0;
      end else if (m_state == M_MEAS) begin
        m_good++;
        if (m_good >= LOCK_FR) m_state = M_LOCK;
      end
    end
    p_locked  = int'(m_state == M_LOCK);
    p_ec      = m_ec;
    have_pend = 1;

    if (hf) begin
      m_nhsf++;
      m_last_hsf = m_idx;
    end
    if (vf) m_nhsf_vsf = m_nhsf;
    if (vf) m_ay = 0;
    else if (hf && m_line_act) m_ay++;
    if (hf) begin
      m_ax = 0;
      m_line_act = 0;
    end else if (bl) begin
      m_ax++;
      m_line_act = 1;
    end
    m_idx++;
    m_phs = hs;
    m_pvs = vs;
  endtask

  task automatic clear_obs();
    ov = 0; ofs = 0; oe = 0; ox = '0; oy = '0; orgb = '0;
  endtask

  task automatic sample_out();
    if (rx_valid === 1'b1) begin
      ov++;
      ox = rx_x;
      oy = rx_y;
      orgb = {rx_r, rx_g, rx_b};
    end
    if (frame_start === 1'b1) ofs++;
    if (err_pulse === 1'b1) oe++;
  endtask

  task automatic check_pending();
    if (have_pend) begin
      chk("rx_valid", 64'(ov), 64'(p_valid));
      if (p_valid != 0) chk("pixel_xy_rgb", {ox, oy, orgb}, {p_x, p_y, p_rgb});
      chk("frame_start", 64'(ofs), 64'(p_fs));
      chk("err_pulse", 64'(oe), 64'(p_err));
      chk("locked", 64'(locked), 64'(p_locked));
      chk("err_count", 64'(err_count), 64'(p_ec));
      have_pend = 0;
    end
  endtask

  // One pixel period is four CLOCK_50 cycles; data is set while vga_clk is
  // low and held across the rising edge. The previous pixel's outputs appear
  // inside this window.
  task automatic send_pix(input bit hs, input bit vs, input bit bl, input logic [23:0] rgb);
    vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = rgb;
    vga_clk = 1'b0;
    clear_obs();
    @(negedge CLOCK_50); sample_out();
    @(negedge CLOCK_50); sample_out(); vga_clk = 1'b1;
    @(negedge CLOCK_50); sample_out();
    @(negedge CLOCK_50); sample_out();
    check_pending();
    model_step(hs, vs, bl, rgb);
  endtask

  task automatic flush();
    vga_clk = 1'b0;
    clear_obs();
    repeat (3) begin
      @(negedge CLOCK_50); sample_out();
    end
    check_pending();
  endtask

  task automatic do_reset();
    flush();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_xy", {rx_x, rx_y}, 64'd0);
    chk("rst_rgb", {rx_r, rx_g, rx_b}, 64'd0);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    model_reset();
    have_pend = 0;
  endtask

  // short_line: line sent one pixel short; vs_w: VS low width in lines;
  // act_line/act_len: line whose active run is act_len; nlines: lines sent.
  task automatic send_frame(input int short_line, input int vs_w, input int act_line,
                            input int act_len, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int p = 0; p < len; p++) begin
        int  alen;
        bit  bl;
        alen = (l == act_line) ? act_len : H_ACTIVE;
        bl = (l >= V_START) && (l < V_START + V_ACTIVE) && (p >= H_START) && (p < H_START + alen);
        send_pix(p >= H_SYNC, l >= vs_w, bl, 24'($urandom));
      end
    end
  endtask

  task automatic nominal(input int n);
    for (int i = 0; i < n; i++) send_frame(-1, V_SYNC, -1, H_ACTIVE, V_TOTAL);
  endtask

  initial begin
    have_pend = 0;
    model_reset();
    clear_obs();
    do_reset();

    // Nominal stream: the first VS fall is seen at the start of frame 2, lock
    // follows two clean frames later.
    nominal(4);
    chk("nominal_locked", 64'(locked), 64'd1);
    chk("nominal_err_count", 64'(err_count), 64'd0);

    // One short line while locked, then relock.
    send_frame($urandom_range(1, 5), V_SYNC, -1, H_ACTIVE, V_TOTAL);
    chk("short_unlocked", 64'(locked), 64'd0);
    chk("short_err_count", 64'(err_count), 64'd1);
    nominal(3);
    chk("short_relocked", 64'(locked), 64'd1);

    // VS held low for one extra line.
    send_frame(-1, V_SYNC + 1, -1, H_ACTIVE, V_TOTAL);
    chk("vsw_unlocked", 64'(locked), 64'd0);
    chk("vsw_err_count", 64'(err_count), 64'd2);
    nominal(3);

    // One active line one pixel short.
    send_frame(-1, V_SYNC, $urandom_range(V_START, V_START + V_ACTIVE - 1),
               H_ACTIVE - 1, V_TOTAL);
    chk("act_err_count", 64'(err_count), 64'd3);
    nominal(1);

    // Reset in the middle of a frame.
    send_frame(-1, V_SYNC, -1, H_ACTIVE, 5);
    do_reset();
    nominal(4);
    chk("post_reset_locked", 64'(locked), 64'd1);
    chk("post_reset_err_count", 64'(err_count), 64'd0);

    // 300 short VS glitches, each a VS-width violation once measuring.
    for (int i = 0; i < 300; i++) begin
      send_pix(1'b1, 1'b0, 1'b0, 24'($urandom));
      send_pix(1'b1, 1'b1, 1'b0, 24'($urandom));
    end
    flush();
    chk("sat_err_count", 64'(err_count), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA timing/pixel transmitter: consumes the outgoing VGA_CLK/VGA_HS/VGA_VS/VGA_BLANK_N/VGA_R/G/B bundle and recovers pixel coordinates, pixel data and frame events.
- Sits beside the vga block in top; used for on-chip self-check of 640x480@60 timing and as the frame/pixel source for collision and score logic.
- Locks to the stream only after consecutive conforming frames; flags timing violations.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line (HS falling edge to next HS falling edge)
- H_SYNC, 96, HS low width in pixel clocks
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (VS falling edge to next VS falling edge)
- V_SYNC, 2, VS low width in lines
- LOCK_FRAMES, 2, consecutive good frames needed to assert locked

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- vga_clk  in  1  VGA pixel clock (25 MHz, derived from CLOCK_50)
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank_n  in  1  high during active video
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- rx_valid  out  1  one-cycle pulse per recovered active pixel
- rx_x  out  10  active pixel column 0..H_ACTIVE-1
- rx_y  out  10  active line 0..V_ACTIVE-1
- rx_r, rx_g, rx_b  out  8 each  captured colour, valid with rx_valid
- frame_start  out  1  one-cycle pulse at each VS falling edge
- locked  out  1  stream conforms to parameters
- err_pulse  out  1  one-cycle pulse on any timing violation
- err_count  out  8  saturating violation count

Behaviour:
- Reset (synchronous, active-high, CLOCK_50): all outputs 0, state HUNT, all counters 0; reset mid-frame discards the frame.
- vga_clk through 2-flop synchroniser; pix_en = one CLOCK_50 cycle on its rising edge. All sync/blank/colour inputs registered every cycle; state updates only when pix_en=1.
- Edge detect on sampled HS/VS at pix_en: hs_fall, vs_fall.
- h_cnt: 0 at hs_fall, else +1 per pix_en; v_cnt: 0 at vs_fall, else +1 per hs_fall. Both 10-bit, saturate at 1023 (no wrap).
- Active pixel: pix_en and blank_n=1 -> rx_valid=1 next cycle with rx_x=ax, rx_y=ay, colour of that sample. ax increments per active pixel, clears at hs_fall; ay increments at hs_fall following a line containing >=1 active pixel, clears at vs_fall.
- Checks (only in MEASURE/LOCKED), each raises err_pulse for one cycle:
  - hs_fall with h_cnt+1 != H_TOTAL
  - HS low width != H_SYNC (checked at HS rising edge)
  - vs_fall with v_cnt+1 != V_TOTAL
  - VS low width != V_SYNC lines
  - hs_fall with ax != 0 and ax != H_ACTIVE
  - vs_fall with ay != V_ACTIVE
  - Simultaneous violations: single err_pulse, err_count +1; saturates at 255, clears only on reset.
- FSM:
  - HUNT: wait vs_fall -> MEASURE, good=0; no err checks.
  - MEASURE: error -> HUNT; vs_fall with clean frame -> good+1; good reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: locked=1; error -> HUNT, locked=0 same cycle as err_pulse.
- frame_start pulses on every vs_fall in any state (except during reset). rx_valid emitted in all states; consumers gate with locked.
- vs_fall and hs_fall in same pix_en: v_cnt<=0, h_cnt<=0, ay<=0, ax<=0.
- Latency: input sample to rx_valid = sync register + 1 cycle; pix_en lags vga_clk rise by 2-3 CLOCK_50 cycles.

Test Plan:
- Nominal: drive ideal 640x480 stream, colour=x[7:0] -> locked=1 after 2nd vs_fall following first; 307200 rx_valid per frame, last (639,479); err_count=0.
- Short line: one line H_TOTAL=799 in locked frame -> err_pulse once, locked=0, err_count=1, relock after 3 further vs_fall.
- Bad VS width: VS low 3 lines -> err_pulse at VS rising edge, state HUNT.
- Active count mismatch: blank_n high 639 pixels on line 100 -> err at that hs_fall, err_count=1.
- Reset mid-frame at line 200: outputs 0, no err_pulse until after next vs_fall; relock after LOCK_FRAMES frames.
- Saturation: 300 injected line errors -> err_count holds 255.
